// File: rtl/csr_reg.sv
// Machine-mode CSR register file serving the execute-stage and interrupt-controller ports.
// Optional 64-bit cycle counter (mcycle/mcycleh, cycle/cycleh) enabled by `define CSR_CYCLE_CNT_EN.
module csr_reg #(
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_wr_en_i,
    input  logic [31:0] ex_wr_addr_i,
    input  logic [31:0] ex_wr_data_i,
    input  logic [31:0] ex_rd_addr_i,
    output logic [31:0] ex_rd_data_o,
    input  logic        clint_wr_en_i,
    input  logic [31:0] clint_wr_addr_i,
    input  logic [31:0] clint_wr_data_i,
    input  logic [31:0] clint_rd_addr_i,
    output logic [31:0] clint_rd_data_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mstatus_o,
    output logic        global_int_en_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
`ifdef CSR_CYCLE_CNT_EN
    logic [63:0] cycle_q, cycle_d;
`endif

    logic [11:0] ex_wa, cl_wa, ex_ra, cl_ra;
    logic        ex_hit, cl_hit;
    logic [31:0] ex_wv, cl_wv;
    logic        unused_addr_hi;

    assign ex_wa = ex_wr_addr_i[11:0];
    assign cl_wa = clint_wr_addr_i[11:0];
    assign ex_ra = ex_rd_addr_i[11:0];
    assign cl_ra = clint_rd_addr_i[11:0];
    assign unused_addr_hi = ^{ex_wr_addr_i[31:12], clint_wr_addr_i[31:12],
                              ex_rd_addr_i[31:12], clint_rd_addr_i[31:12]};

    // Read-only aliases and unimplemented CSRs are not writable, so they never forward either.
    function automatic logic wr_ok(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE: wr_ok = 1'b1;
`ifdef CSR_CYCLE_CNT_EN
            A_MCYCLE, A_MCYCLEH: wr_ok = 1'b1;
`endif
            default: wr_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] wr_mask(input logic [11:0] a, input logic [31:0] d);
        case (a)
            A_MSTATUS:      wr_mask = (d & 32'h0000_0088) | 32'h0000_1800;
            A_MTVEC,
            A_MEPC:         wr_mask = {d[31:2], 2'b00};
            default:        wr_mask = d;
        endcase
    endfunction

    assign cl_hit = clint_wr_en_i && wr_ok(cl_wa);
    assign ex_hit = ex_wr_en_i && wr_ok(ex_wa) && !(clint_wr_en_i && (cl_wa == ex_wa));
    assign cl_wv  = wr_mask(cl_wa, clint_wr_data_i);
    assign ex_wv  = wr_mask(ex_wa, ex_wr_data_i);

    function automatic logic [31:0] reg_rd(input logic [11:0] a);
        case (a)
            A_MSTATUS:  reg_rd = mstatus_q;
            A_MIE:      reg_rd = mie_q;
            A_MTVEC:    reg_rd = mtvec_q;
            A_MSCRATCH: reg_rd = mscratch_q;
            A_MEPC:     reg_rd = mepc_q;
            A_MCAUSE:   reg_rd = mcause_q;
`ifdef CSR_CYCLE_CNT_EN
            A_MCYCLE,  A_CYCLE:  reg_rd = cycle_q[31:0];
            A_MCYCLEH, A_CYCLEH: reg_rd = cycle_q[63:32];
`endif
            default:    reg_rd = 32'h0;
        endcase
    endfunction

    always_comb begin
        ex_rd_data_o = reg_rd(ex_ra);
        if (cl_hit && cl_wa == ex_ra)      ex_rd_data_o = cl_wv;
        else if (ex_hit && ex_wa == ex_ra) ex_rd_data_o = ex_wv;
    end

    always_comb begin
        clint_rd_data_o = reg_rd(cl_ra);
        if (cl_hit && cl_wa == cl_ra)      clint_rd_data_o = cl_wv;
        else if (ex_hit && ex_wa == cl_ra) clint_rd_data_o = ex_wv;
    end

    function automatic logic [31:0] nxt(input logic [31:0] q, input logic [11:0] a,
                                        input logic ch, input logic [11:0] ca, input logic [31:0] cv,
                                        input logic eh, input logic [11:0] ea, input logic [31:0] ev);
        if (ch && ca == a)      nxt = cv;
        else if (eh && ea == a) nxt = ev;
        else                    nxt = q;
    endfunction

    always_comb begin
        mstatus_d  = nxt(mstatus_q,  A_MSTATUS,  cl_hit, cl_wa, cl_wv, ex_hit, ex_wa, ex_wv);
        mie_d      = nxt(mie_q,      A_MIE,      cl_hit, cl_wa, cl_wv, ex_hit, ex_wa, ex_wv);
        mtvec_d    = nxt(mtvec_q,    A_MTVEC,    cl_hit, cl_wa, cl_wv, ex_hit, ex_wa, ex_wv);
        mscratch_d = nxt(mscratch_q, A_MSCRATCH, cl_hit, cl_wa, cl_wv, ex_hit, ex_wa, ex_wv);
        mepc_d     = nxt(mepc_q,     A_MEPC,     cl_hit, cl_wa, cl_wv, ex_hit, ex_wa, ex_wv);
        mcause_d   = nxt(mcause_q,   A_MCAUSE,   cl_hit, cl_wa, cl_wv, ex_hit, ex_wa, ex_wv);
    end

`ifdef CSR_CYCLE_CNT_EN
    logic lo_wr, hi_wr;
    assign lo_wr = (cl_hit && cl_wa == A_MCYCLE)  || (ex_hit && ex_wa == A_MCYCLE);
    assign hi_wr = (cl_hit && cl_wa == A_MCYCLEH) || (ex_hit && ex_wa == A_MCYCLEH);

    // A write to either half freezes the whole counter for that cycle.
    always_comb begin
        cycle_d = cycle_q + 64'd1;
        if (lo_wr || hi_wr) begin
            cycle_d = cycle_q;
            if (lo_wr) cycle_d[31:0]  = nxt(cycle_q[31:0],  A_MCYCLE,  cl_hit, cl_wa, cl_wv, ex_hit, ex_wa, ex_wv);
            if (hi_wr) cycle_d[63:32] = nxt(cycle_q[63:32], A_MCYCLEH, cl_hit, cl_wa, cl_wv, ex_hit, ex_wa, ex_wv);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_q <= 64'h0;
        else        cycle_q <= cycle_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q  <= MSTATUS_RESET;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    // Pure register outputs: no forwarding, so no loop back through the interrupt controller.
    assign csr_mtvec_o     = mtvec_q;
    assign csr_mepc_o      = mepc_q;
    assign csr_mstatus_o   = mstatus_q;
    assign global_int_en_o = mstatus_q[3];

endmodule

// File: tb/tb_csr_reg.sv
// Directed, table-driven bench for csr_reg; counter expectations follow CSR_CYCLE_CNT_EN.
module tb_csr_reg;

`ifdef CSR_CYCLE_CNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_wr_en_i, clint_wr_en_i;
    logic [31:0] ex_wr_addr_i, ex_wr_data_i, ex_rd_addr_i, ex_rd_data_o;
    logic [31:0] clint_wr_addr_i, clint_wr_data_i, clint_rd_addr_i, clint_rd_data_o;
    logic [31:0] csr_mtvec_o, csr_mepc_o, csr_mstatus_o;
    logic        global_int_en_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_reg dut (
        .clk(clk), .rst_n(rst_n),
        .ex_wr_en_i(ex_wr_en_i), .ex_wr_addr_i(ex_wr_addr_i), .ex_wr_data_i(ex_wr_data_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_o(ex_rd_data_o),
        .clint_wr_en_i(clint_wr_en_i), .clint_wr_addr_i(clint_wr_addr_i),
        .clint_wr_data_i(clint_wr_data_i), .clint_rd_addr_i(clint_rd_addr_i),
        .clint_rd_data_o(clint_rd_data_o),
        .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o), .csr_mstatus_o(csr_mstatus_o),
        .global_int_en_o(global_int_en_o)
    );

    typedef struct {
        logic        ex_en;
        logic [31:0] ex_a, ex_d;
        logic        cl_en;
        logic [31:0] cl_a, cl_d;
        logic [31:0] ex_ra, cl_ra;
        logic [31:0] exp_ex_rd, exp_cl_rd;
        logic [31:0] exp_mstatus, exp_mepc, exp_mtvec;
        logic        exp_gie;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ee, input logic [31:0] ea, input logic [31:0] ed,
                         input logic ce, input logic [31:0] ca, input logic [31:0] cd,
                         input logic [31:0] era, input logic [31:0] cra);
        ex_wr_en_i = ee; ex_wr_addr_i = ea; ex_wr_data_i = ed;
        clint_wr_en_i = ce; clint_wr_addr_i = ca; clint_wr_data_i = cd;
        ex_rd_addr_i = era; clint_rd_addr_i = cra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          ex_en ex_a           ex_d           cl_en cl_a     cl_d           ex_ra          cl_ra          exp_ex_rd      exp_cl_rd      mstatus        mepc   mtvec          gie
        vt[0]  = '{1'b1, 32'h300,       32'hFFFF_FFFF, 1'b0, 32'h0,   32'h0,         32'h300,       32'h300,       32'h0000_1888, 32'h0000_1888, 32'h1888, 32'h0,   32'h0,    1'b1};
        vt[1]  = '{1'b1, 32'h341,       32'h0000_0103, 1'b1, 32'h341, 32'h0000_0200, 32'h341,       32'h341,       32'h0000_0200, 32'h0000_0200, 32'h1888, 32'h200, 32'h0,    1'b1};
        vt[2]  = '{1'b1, 32'h341,       32'h0000_0103, 1'b0, 32'h0,   32'h0,         32'h341,       32'h300,       32'h0000_0100, 32'h0000_1888, 32'h1888, 32'h100, 32'h0,    1'b1};
        vt[3]  = '{1'b1, 32'h305,       32'h0000_1007, 1'b0, 32'h0,   32'h0,         32'h305,       32'h305,       32'h0000_1004, 32'h0000_1004, 32'h1888, 32'h100, 32'h1004, 1'b1};
        vt[4]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h341, 32'h0000_0080, 32'h300,       32'h341,       32'h0000_1888, 32'h0000_0080, 32'h1888, 32'h80,  32'h1004, 1'b1};
        vt[5]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h300, 32'h0000_1880, 32'h300,       32'h341,       32'h0000_1880, 32'h0000_0080, 32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[6]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h342, 32'd11,        32'h300,       32'h342,       32'h0000_1880, 32'd11,        32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[7]  = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0,   32'h0,         32'h342,       32'h300,       32'd11,        32'h0000_1880, 32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[8]  = '{1'b1, 32'h340,       32'hDEAD_BEEF, 1'b0, 32'h0,   32'h0,         32'h340,       32'h340,       32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[9]  = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0,   32'h0,         32'h340,       32'h7C0,       32'hDEAD_BEEF, 32'h0,         32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[10] = '{1'b1, 32'h7C0,       32'h0000_1234, 1'b0, 32'h0,   32'h0,         32'h7C0,       32'h340,       32'h0,         32'hDEAD_BEEF, 32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[11] = '{1'b1, 32'hFFFF_F304, 32'h0000_0055, 1'b0, 32'h0,   32'h0,         32'h304,       32'hABC0_0304, 32'h0000_0055, 32'h0000_0055, 32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[12] = '{1'b1, 32'h304,       32'h0000_00AA, 1'b1, 32'h340, 32'h1234_5678, 32'h340,       32'h304,       32'h1234_5678, 32'h0000_00AA, 32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[13] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0,   32'h0,         32'h304,       32'h340,       32'h0000_00AA, 32'h1234_5678, 32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[14] = '{1'b1, 32'h340,       32'h0000_0111, 1'b1, 32'h340, 32'h0000_0222, 32'h340,       32'h340,       32'h0000_0222, 32'h0000_0222, 32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[15] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0,   32'h0,         32'h340,       32'h342,       32'h0000_0222, 32'd11,        32'h1880, 32'h80,  32'h1004, 1'b0};
        vt[16] = '{1'b1, 32'h300,       32'hFFFF_FFFF, 1'b1, 32'h300, 32'h0,         32'h300,       32'h300,       32'h0000_1800, 32'h0000_1800, 32'h1800, 32'h80,  32'h1004, 1'b0};
        vt[17] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h300, 32'h0000_0008, 32'h300,       32'h305,       32'h0000_1808, 32'h0000_1004, 32'h1808, 32'h80,  32'h1004, 1'b1};
        vt[18] = '{1'b1, 32'h305,       32'h0000_0002, 1'b0, 32'h0,   32'h0,         32'h305,       32'h341,       32'h0000_0000, 32'h0000_0080, 32'h1808, 32'h80,  32'h0,    1'b1};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #12;
        chk("rst_mstatus", csr_mstatus_o, 32'h0000_1800);
        chk("rst_mtvec",   csr_mtvec_o,   32'h0);
        chk("rst_mepc",    csr_mepc_o,    32'h0);
        chk("rst_gie",     {31'h0, global_int_en_o}, 32'h0);

        // Counter starts at 0 after release and counts up each edge.
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'hC00, 32'hC80);
        #1;
        chk("cyc0", ex_rd_data_o, 32'h0);
        tick();
        chk("cyc1", ex_rd_data_o, CNT ? 32'h1 : 32'h0);
        tick();
        chk("cyc2", ex_rd_data_o, CNT ? 32'h2 : 32'h0);
        chk("cych", clint_rd_data_o, 32'h0);

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].ex_en, vt[i].ex_a, vt[i].ex_d, vt[i].cl_en, vt[i].cl_a, vt[i].cl_d,
                  vt[i].ex_ra, vt[i].cl_ra);
            #1;
            chk($sformatf("v%0d_ex_rd", i), ex_rd_data_o, vt[i].exp_ex_rd);
            chk($sformatf("v%0d_cl_rd", i), clint_rd_data_o, vt[i].exp_cl_rd);
            tick();
            chk($sformatf("v%0d_mstatus", i), csr_mstatus_o, vt[i].exp_mstatus);
            chk($sformatf("v%0d_mepc", i), csr_mepc_o, vt[i].exp_mepc);
            chk($sformatf("v%0d_mtvec", i), csr_mtvec_o, vt[i].exp_mtvec);
            chk($sformatf("v%0d_gie", i), {31'h0, global_int_en_o}, {31'h0, vt[i].exp_gie});
        end

        // Counter wrap: load high half, then low half, then watch it roll over.
        drive(1'b1, 32'hB80, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'hB80, 32'h7C0);
        #1;
        chk("mcycleh_fwd", ex_rd_data_o, CNT ? 32'hFFFF_FFFF : 32'h0);
        chk("unimpl_rd", clint_rd_data_o, 32'h0);
        tick();
        drive(1'b1, 32'hB00, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0, 32'hB00, 32'hB80);
        #1;
        chk("mcycle_fwd", ex_rd_data_o, CNT ? 32'hFFFF_FFFE : 32'h0);
        chk("mcycleh_hold", clint_rd_data_o, CNT ? 32'hFFFF_FFFF : 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'hC00, 32'hC80);
        #1;
        chk("wrap0_lo", ex_rd_data_o, CNT ? 32'hFFFF_FFFE : 32'h0);
        chk("wrap0_hi", clint_rd_data_o, CNT ? 32'hFFFF_FFFF : 32'h0);
        tick();
        chk("wrap1_lo", ex_rd_data_o, CNT ? 32'hFFFF_FFFF : 32'h0);
        chk("wrap1_hi", clint_rd_data_o, CNT ? 32'hFFFF_FFFF : 32'h0);
        tick();
        chk("wrap2_lo", ex_rd_data_o, 32'h0);
        chk("wrap2_hi", clint_rd_data_o, 32'h0);
        tick();
        chk("wrap3_lo", ex_rd_data_o, CNT ? 32'h1 : 32'h0);
        chk("wrap3_hi", clint_rd_data_o, 32'h0);

        // Writes to the read-only alias neither forward nor stall the counter.
        drive(1'b1, 32'hC00, 32'h0, 1'b1, 32'hC80, 32'h5, 32'hC00, 32'hC80);
        #1;
        chk("ro_fwd_lo", ex_rd_data_o, CNT ? 32'h1 : 32'h0);
        chk("ro_fwd_hi", clint_rd_data_o, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'hC00, 32'hC80);
        #1;
        chk("ro_cnt_lo", ex_rd_data_o, CNT ? 32'h2 : 32'h0);
        chk("ro_cnt_hi", clint_rd_data_o, 32'h0);

        // Reset asserted mid-cycle with a write pending: everything back to reset, write lost.
        drive(1'b1, 32'h341, 32'h0000_0044, 1'b1, 32'h342, 32'h0000_0077, 32'h342, 32'h340);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_mepc", csr_mepc_o, 32'h0);
        chk("mrst_mstatus", csr_mstatus_o, 32'h0000_1800);
        chk("mrst_gie", {31'h0, global_int_en_o}, 32'h0);
        tick();
        chk("mrst_mepc_edge", csr_mepc_o, 32'h0);
        chk("mrst_mtvec", csr_mtvec_o, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h342, 32'h340);
        rst_n = 1'b1;
        #1;
        chk("mrst_mcause", ex_rd_data_o, 32'h0);
        chk("mrst_mscratch", clint_rd_data_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
